// File: rtl/mps_op_cmd_arbiter_if.sv
// Request, status and FSM-handshake bundle between the requesters/op FSM and the command arbiter.
// slave = arbiter side, master = requesters and operation FSM side.
interface mps_op_cmd_arbiter_if;
  logic [2:0] i_req_on;
  logic [2:0] i_req_off;
  logic [2:0] i_src_en;
  logic       i_intl;
  logic       i_err_clr;
  logic [3:0] i_on_state;
  logic [3:0] i_off_state;
  logic       o_op_on_flag;
  logic       o_op_off_flag;
  logic       o_busy;
  logic [1:0] o_grant_src;
  logic       o_pwr_on;
  logic       o_done;
  logic       o_rej;
  logic       o_err;
  logic [1:0] o_err_code;

  modport slave (
    input  i_req_on, i_req_off, i_src_en, i_intl, i_err_clr, i_on_state, i_off_state,
    output o_op_on_flag, o_op_off_flag, o_busy, o_grant_src, o_pwr_on,
           o_done, o_rej, o_err, o_err_code
  );

  modport master (
    output i_req_on, i_req_off, i_src_en, i_intl, i_err_clr, i_on_state, i_off_state,
    input  o_op_on_flag, o_op_off_flag, o_busy, o_grant_src, o_pwr_on,
           o_done, o_rej, o_err, o_err_code
  );
endinterface

// File: rtl/mps_op_cmd_arbiter.sv
// Priority arbiter/sequencer for MPS on/off commands. Latency: request to start flag is 2 edges, interlock to off flag is 2 edges.
// No queuing: on-requests while busy are rejected with o_rej. Optional timeout/FAULT path under MPS_CMD_TIMEOUT_EN.
module mps_op_cmd_arbiter #(
`ifdef MPS_CMD_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
`endif
  parameter logic [3:0]  ON_DONE_ST  = 4'd13,
  parameter logic [3:0]  OFF_DONE_ST = 4'd4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mps_op_cmd_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_ON, S_WAIT_ON, S_ISSUE_OFF, S_WAIT_OFF, S_FAULT
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] pend_on, pend_off;
  logic [2:0] on_req, off_req;
  logic       intl_q;
  logic       on_acc, rej_nxt, to_hit;
  logic [1:0] grant_nxt, code_set;
  logic       pwr_nxt, done_nxt, err_set;

  function automatic logic [1:0] low_idx(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  assign on_req  = bus.i_req_on  & bus.i_src_en;
  assign off_req = bus.i_req_off & bus.i_src_en;

  // An on-request is only taken when nothing else can claim the next IDLE decision.
  assign on_acc  = (state == S_IDLE) && !(|pend_on) && !(|pend_off) && !(|off_req)
                   && !bus.o_pwr_on && !bus.i_intl;
  assign rej_nxt = (|on_req) && (state != S_FAULT) && !on_acc;

`ifdef MPS_CMD_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      to_cnt <= 32'd0;
    else if (state == S_ISSUE_ON || state == S_ISSUE_OFF)
      to_cnt <= 32'd0;
    else if (state == S_WAIT_ON || state == S_WAIT_OFF)
      to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit = (state == S_WAIT_ON || state == S_WAIT_OFF) && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = bus.o_grant_src;
    pwr_nxt   = bus.o_pwr_on;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    code_set  = 2'b00;
    case (state)
      S_IDLE: begin
        if (intl_q && bus.o_pwr_on) begin
          state_nxt = S_ISSUE_OFF;
          grant_nxt = 2'd3;
        end else if (|pend_off) begin
          state_nxt = S_ISSUE_OFF;
          grant_nxt = low_idx(pend_off);
        end else if ((|pend_on) && !intl_q && !bus.o_pwr_on) begin
          state_nxt = S_ISSUE_ON;
          grant_nxt = low_idx(pend_on);
        end
      end
      S_ISSUE_ON:  state_nxt = S_WAIT_ON;
      S_ISSUE_OFF: state_nxt = S_WAIT_OFF;
      S_WAIT_ON: begin
        if (bus.i_on_state == ON_DONE_ST) begin
          state_nxt = S_IDLE;
          pwr_nxt   = 1'b1;
          done_nxt  = 1'b1;
        end else if (intl_q) begin
          state_nxt = S_ISSUE_OFF;
          grant_nxt = 2'd3;
          err_set   = 1'b1;
          code_set  = 2'b10;
        end else if (|pend_off) begin
          state_nxt = S_ISSUE_OFF;
          grant_nxt = low_idx(pend_off);
        end else if (to_hit) begin
          state_nxt = S_FAULT;
          err_set   = 1'b1;
          code_set  = 2'b01;
        end
      end
      S_WAIT_OFF: begin
        if (bus.i_off_state == OFF_DONE_ST) begin
          state_nxt = S_IDLE;
          pwr_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end else if (to_hit) begin
          state_nxt = S_FAULT;
          err_set   = 1'b1;
          code_set  = 2'b01;
        end
      end
      S_FAULT: begin
        if (bus.i_err_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= S_IDLE;
      pend_on           <= 3'b000;
      pend_off          <= 3'b000;
      intl_q            <= 1'b0;
      bus.o_op_on_flag  <= 1'b0;
      bus.o_op_off_flag <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_grant_src   <= 2'd0;
      bus.o_pwr_on      <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_rej         <= 1'b0;
      bus.o_err         <= 1'b0;
      bus.o_err_code    <= 2'b00;
    end else begin
      state   <= state_nxt;
      intl_q  <= bus.i_intl;
      pend_on <= on_acc ? on_req : 3'b000;
      // Off requests are dropped once an off is in flight or the block is faulted.
      if (state == S_ISSUE_OFF || state == S_WAIT_OFF || state == S_FAULT)
        pend_off <= 3'b000;
      else
        pend_off <= pend_off | off_req;
      bus.o_op_on_flag  <= (state_nxt == S_ISSUE_ON);
      bus.o_op_off_flag <= (state_nxt == S_ISSUE_OFF) ||
                           ((state_nxt == S_FAULT) && (state != S_FAULT));
      bus.o_busy        <= (state_nxt != S_IDLE);
      bus.o_grant_src   <= grant_nxt;
      bus.o_pwr_on      <= pwr_nxt;
      bus.o_done        <= done_nxt;
      bus.o_rej         <= rej_nxt;
      if (err_set) begin
        bus.o_err      <= 1'b1;
        bus.o_err_code <= code_set;
      end else if (bus.i_err_clr) begin
        bus.o_err      <= 1'b0;
        bus.o_err_code <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mps_op_cmd_arbiter.sv
// Directed bench for mps_op_cmd_arbiter; outputs sampled 1 time unit after each rising edge.
// Timeout/FAULT steps run only when MPS_CMD_TIMEOUT_EN is defined (TIMEOUT_CYC = 100).
module tb_mps_op_cmd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n_on  = 0;
  int   n_off = 0;
  int   off_base;

  always #5 clk = ~clk;

  mps_op_cmd_arbiter_if bus();

  mps_op_cmd_arbiter #(
`ifdef MPS_CMD_TIMEOUT_EN
    .TIMEOUT_CYC(100),
`endif
    .ON_DONE_ST(4'd13),
    .OFF_DONE_ST(4'd4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.o_op_on_flag === 1'b1)  n_on  <= n_on + 1;
    if (bus.o_op_off_flag === 1'b1) n_off <= n_off + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.i_req_on    = 3'b000;
    bus.i_req_off   = 3'b000;
    bus.i_src_en    = 3'b111;
    bus.i_intl      = 1'b0;
    bus.i_err_clr   = 1'b0;
    bus.i_on_state  = 4'd0;
    bus.i_off_state = 4'd0;
    tick(); tick();
    chk("rst_outs", {bus.o_op_on_flag, bus.o_op_off_flag, bus.o_busy, bus.o_grant_src, bus.o_pwr_on,
                     bus.o_done, bus.o_rej, bus.o_err, bus.o_err_code}, 32'h0);
    rst = 1'b0;
    tick();

    // Requester 1 powers on; FSM completes 50 cycles after the request edge.
    bus.i_req_on = 3'b010; tick(); bus.i_req_on = 3'b000;
    chk("t1_rej0", bus.o_rej, 1'b0);
    chk("t1_flag_early", bus.o_op_on_flag, 1'b0);
    tick();
    chk("t1_flag", bus.o_op_on_flag, 1'b1);
    chk("t1_grant", bus.o_grant_src, 2'd1);
    chk("t1_busy", bus.o_busy, 1'b1);
    tick();
    chk("t1_flag_w", bus.o_op_on_flag, 1'b0);
    repeat (47) tick();
    bus.i_on_state = 4'd13; tick();
    chk("t1_done", bus.o_done, 1'b1);
    chk("t1_pwr", bus.o_pwr_on, 1'b1);
    chk("t1_idle", bus.o_busy, 1'b0);
    bus.i_on_state = 4'd0; tick();
    chk("t1_done_pulse", bus.o_done, 1'b0);
    chk("t1_nflag", n_on, 1);

    // On-request while already powered on is rejected.
    bus.i_req_on = 3'b001; tick(); bus.i_req_on = 3'b000;
    chk("t1b_rej", bus.o_rej, 1'b1);
    tick();
    chk("t1b_rej_pulse", bus.o_rej, 1'b0);
    chk("t1b_noflag", bus.o_op_on_flag, 1'b0);
    chk("t1b_idle", bus.o_busy, 1'b0);

    // Same-cycle off (req 2) and on (req 0): off wins, on rejected.
    bus.i_req_off = 3'b100; bus.i_req_on = 3'b001; tick();
    bus.i_req_off = 3'b000; bus.i_req_on = 3'b000;
    chk("t2_rej", bus.o_rej, 1'b1);
    chk("t2_flag_early", bus.o_op_off_flag, 1'b0);
    tick();
    chk("t2_flag", bus.o_op_off_flag, 1'b1);
    chk("t2_grant", bus.o_grant_src, 2'd2);
    chk("t2_rej_pulse", bus.o_rej, 1'b0);
    tick();
    chk("t2_flag_w", bus.o_op_off_flag, 1'b0);
    chk("t2_busy", bus.o_busy, 1'b1);
    bus.i_off_state = 4'd4; tick();
    chk("t2_done", bus.o_done, 1'b1);
    chk("t2_pwr", bus.o_pwr_on, 1'b0);
    chk("t2_idle", bus.o_busy, 1'b0);
    bus.i_off_state = 4'd0;

    // Interlock during WAIT_ON aborts with error code 10.
    bus.i_req_on = 3'b001; tick(); bus.i_req_on = 3'b000;
    tick();
    chk("t3_flag_on", bus.o_op_on_flag, 1'b1);
    chk("t3_grant0", bus.o_grant_src, 2'd0);
    tick();
    bus.i_intl = 1'b1; tick();
    chk("t3_off_early", bus.o_op_off_flag, 1'b0);
    tick();
    chk("t3_off_flag", bus.o_op_off_flag, 1'b1);
    chk("t3_grant3", bus.o_grant_src, 2'd3);
    chk("t3_err", bus.o_err, 1'b1);
    chk("t3_code", bus.o_err_code, 2'b10);
    bus.i_req_on = 3'b010; tick(); bus.i_req_on = 3'b000;
    chk("t3_rej", bus.o_rej, 1'b1);
    bus.i_off_state = 4'd4; tick();
    chk("t3_done", bus.o_done, 1'b1);
    chk("t3_err_sticky", bus.o_err, 1'b1);
    bus.i_off_state = 4'd0; bus.i_intl = 1'b0;
    bus.i_err_clr = 1'b1; tick(); bus.i_err_clr = 1'b0;
    chk("t3_err_clr", {bus.o_err, bus.o_err_code}, 3'b000);

    // Masked requester is ignored entirely.
    bus.i_src_en = 3'b110; bus.i_req_on = 3'b001; tick(); bus.i_req_on = 3'b000;
    chk("t4_norej", bus.o_rej, 1'b0);
    tick();
    chk("t4_noflag", bus.o_op_on_flag, 1'b0);
    chk("t4_idle", bus.o_busy, 1'b0);
    bus.i_src_en = 3'b111;

`ifdef MPS_CMD_TIMEOUT_EN
    // FSM stuck: FAULT 100 cycles into WAIT_ON, one off flag, requests ignored.
    bus.i_req_on = 3'b010; tick(); bus.i_req_on = 3'b000;
    tick(); tick();
    chk("t5_wait", bus.o_busy, 1'b1);
    off_base = n_off;
    repeat (99) tick();
    chk("t5_pre_err", bus.o_err, 1'b0);
    chk("t5_pre_off", bus.o_op_off_flag, 1'b0);
    tick();
    chk("t5_err", bus.o_err, 1'b1);
    chk("t5_code", bus.o_err_code, 2'b01);
    chk("t5_off_flag", bus.o_op_off_flag, 1'b1);
    tick();
    chk("t5_off_pulse", bus.o_op_off_flag, 1'b0);
    bus.i_req_on = 3'b001; bus.i_req_off = 3'b001; tick();
    bus.i_req_on = 3'b000; bus.i_req_off = 3'b000;
    chk("t5_norej", bus.o_rej, 1'b0);
    tick();
    chk("t5_noflags", {bus.o_op_on_flag, bus.o_op_off_flag}, 2'b00);
    chk("t5_fault_busy", bus.o_busy, 1'b1);
    tick();
    chk("t5_noff", n_off - off_base, 1);
    bus.i_err_clr = 1'b1; tick(); bus.i_err_clr = 1'b0;
    chk("t5_clr", {bus.o_busy, bus.o_err, bus.o_err_code}, 4'b0000);
    tick();
    chk("t5_stay_idle", bus.o_busy, 1'b0);
`endif

    // Asynchronous reset in WAIT_ON, then normal acceptance.
    bus.i_req_on = 3'b100; tick(); bus.i_req_on = 3'b000;
    tick();
    chk("t6_grant2", bus.o_grant_src, 2'd2);
    tick();
    chk("t6_wait", bus.o_busy, 1'b1);
    #2; rst = 1'b1; #1;
    chk("t6_async_rst", {bus.o_op_on_flag, bus.o_op_off_flag, bus.o_busy, bus.o_grant_src, bus.o_pwr_on,
                         bus.o_done, bus.o_rej, bus.o_err, bus.o_err_code}, 32'h0);
    tick();
    rst = 1'b0;
    bus.i_req_on = 3'b010; tick(); bus.i_req_on = 3'b000;
    tick();
    chk("t6_flag", bus.o_op_on_flag, 1'b1);
    chk("t6_grant1", bus.o_grant_src, 2'd1);
    tick();
    chk("t6_busy", bus.o_busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
